// File: rtl/des_pkg.sv
// Shared DES key-schedule constants, state encoding and rotation helpers.
// C||D layout: bits [27:0] hold C, [55:28] hold D, index 0 = DES bit 1 of each half.
package des_pkg;

   localparam int DES_ROUNDS = 16;
   localparam int KEY_W      = 64;
   localparam int CD_W       = 56;
   localparam int HALF_W     = 28;
   localparam int SUBKEY_W   = 48;

   // Entry n holds the shift of DES round n+1.
   localparam int unsigned SHIFT_SCHEDULE [DES_ROUNDS] =
      '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   localparam int PC1_TABLE [CD_W] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ks_state_t;

   function automatic int unsigned shift_for_round(input logic [3:0] rnd0);
      return SHIFT_SCHEDULE[rnd0];
   endfunction

   // DES left shift moves bit i+k into position i; with index 0 = DES bit 1
   // that is a right shift of the vector.
   function automatic logic [HALF_W-1:0] rotl_half(input logic [HALF_W-1:0] h,
                                                    input int unsigned k);
      return (h >> k) | (h << (HALF_W - k));
   endfunction

   function automatic logic [HALF_W-1:0] rotr_half(input logic [HALF_W-1:0] h,
                                                    input int unsigned k);
      return (h << k) | (h >> (HALF_W - k));
   endfunction

   function automatic logic [CD_W-1:0] rotl_cd(input logic [CD_W-1:0] cd,
                                               input int unsigned k);
      return {rotl_half(cd[CD_W-1:HALF_W], k), rotl_half(cd[HALF_W-1:0], k)};
   endfunction

   function automatic logic [CD_W-1:0] rotr_cd(input logic [CD_W-1:0] cd,
                                               input int unsigned k);
      return {rotr_half(cd[CD_W-1:HALF_W], k), rotr_half(cd[HALF_W-1:0], k)};
   endfunction

endpackage

// File: rtl/permuted_choice_1.sv
// Combinational DES PC-1: 64-bit key (index i = DES bit i+1) to 56-bit C||D.
module permuted_choice_1
   import des_pkg::*;
(
   input  logic [KEY_W-1:0] i_key,
   output logic [CD_W-1:0]  o_cd
);

   // Parity bits (DES bits 8,16,..,64) never reach the schedule.
   logic w_parity_unused;
   assign w_parity_unused = ^{i_key[7], i_key[15], i_key[23], i_key[31],
                              i_key[39], i_key[47], i_key[55], i_key[63]};

   generate
      for (genvar gi = 0; gi < CD_W; gi++) begin : g_pc1
         assign o_cd[gi] = i_key[PC1_TABLE[gi] - 1];
      end
   endgenerate

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: loads a key through PC-1, then hands out the
// sixteen C||D round values (encrypt or decrypt order) over a valid/ready port.
module des_key_schedule
   import des_pkg::*;
#(
   parameter int NUM_ROUNDS = DES_ROUNDS
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_valid,
   output logic             key_ready,
   input  logic [KEY_W-1:0] key_in,
   input  logic             decrypt,
   output logic             ks_valid,
   input  logic             ks_ready,
   output logic [CD_W-1:0]  ks_cd,
   output logic [3:0]       ks_round,
   output logic             busy
);

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

   ks_state_t        r_state;
   logic             r_mode;
   logic             r_valid;
   logic [CD_W-1:0]  r_cd;
   logic [3:0]       r_round;

   logic [CD_W-1:0]  w_pc1;
   logic [CD_W-1:0]  w_load_cd;
   logic [CD_W-1:0]  w_next_cd;
   logic             w_last;

   permuted_choice_1 u_pc1 (
      .i_key (key_in),
      .o_cd  (w_pc1)
   );

   // Decrypt starts from CD16, which equals PC1(key) since the shifts sum to 28.
   assign w_load_cd = decrypt ? w_pc1 : rotl_cd(w_pc1, shift_for_round(4'd0));

   // Encrypt steps to round r_round+2, decrypt undoes round 16-r_round.
   assign w_next_cd = r_mode ? rotr_cd(r_cd, shift_for_round(4'd15 - r_round))
                             : rotl_cd(r_cd, shift_for_round(r_round + 4'd1));

   assign w_last = (r_round == LAST_ROUND);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_mode  <= 1'b0;
         r_valid <= 1'b0;
         r_cd    <= '0;
         r_round <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (key_valid) begin
                  r_state <= ST_RUN;
                  r_mode  <= decrypt;
                  r_cd    <= w_load_cd;
                  r_round <= '0;
                  r_valid <= 1'b1;
               end
            end
            ST_RUN: begin
               if (r_valid && ks_ready) begin
                  if (w_last) begin
                     r_valid <= 1'b0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_round <= r_round + 4'd1;
                     r_cd    <= w_next_cd;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign key_ready = (r_state == ST_IDLE);
   assign busy      = (r_state == ST_RUN);
   assign ks_valid  = r_valid;
   assign ks_cd     = r_cd;
   assign ks_round  = r_round;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: directed DES vectors, backpressure,
// back-to-back loads, wrap consistency on random keys and mid-run reset.
module tb_des_key_schedule;

   typedef struct {
      logic [3:0]  round;
      logic        chk_sk;
      logic [47:0] sk;
      logic        chk_cd;
      logic [55:0] cd;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        key_valid;
   logic        key_ready;
   logic [63:0] key_in;
   logic        decrypt;
   logic        ks_valid;
   logic        ks_ready;
   logic [55:0] ks_cd;
   logic [3:0]  ks_round;
   logic        busy;

   des_key_schedule #(.NUM_ROUNDS(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_in    (key_in),
      .decrypt   (decrypt),
      .ks_valid  (ks_valid),
      .ks_ready  (ks_ready),
      .ks_cd     (ks_cd),
      .ks_round  (ks_round),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int hs_count = 0;
   exp_t sb[$];

   localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
   localparam logic [27:0] C1_DES = 28'b1110000110011001010101011111;
   localparam logic [27:0] D1_DES = 28'b1010101011001100111100011110;

   // Published subkeys K1..K16 for KEY_A, DES bit 1 as MSB.
   localparam logic [47:0] K_TAB [16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
   };

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] rev64(input logic [63:0] k);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[i] = k[63 - i];
      return r;
   endfunction

   function automatic logic [27:0] rev28(input logic [27:0] x);
      logic [27:0] r;
      for (int i = 0; i < 28; i++) r[i] = x[27 - i];
      return r;
   endfunction

   // k written with DES bit 1 as MSB: DES bit n = k[64-n].
   function automatic logic [55:0] pc1_model(input logic [63:0] k);
      logic [55:0] cd;
      for (int i = 0; i < 56; i++) cd[i] = k[64 - PC1_T[i]];
      return cd;
   endfunction

   function automatic logic [47:0] pc2_model(input logic [55:0] cd);
      logic [47:0] sk;
      for (int j = 0; j < 48; j++) sk[47 - j] = cd[PC2_T[j] - 1];
      return sk;
   endfunction

   function automatic logic [55:0] brot(input logic [55:0] cd, input int k, input bit left);
      logic [55:0] r;
      for (int i = 0; i < 28; i++) begin
         int src;
         src = left ? (i + k) % 28 : (i + 28 - k) % 28;
         r[i]      = cd[src];
         r[28 + i] = cd[28 + src];
      end
      return r;
   endfunction

   // Monitor: pops expectations on every handshake and checks stall stability.
   exp_t        mon_e;
   bit          prev_stall = 0;
   logic [55:0] prev_cd;
   logic [3:0]  prev_round;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 0;
      end else begin
         if (prev_stall && ks_valid) begin
            check("stall_cd_stable", {8'h0, ks_cd}, {8'h0, prev_cd});
            check("stall_round_stable", {60'h0, ks_round}, {60'h0, prev_round});
         end
         if (ks_valid && ks_ready) begin
            $display("hs round=%0d cd=%h sk=%h", ks_round, ks_cd, pc2_model(ks_cd));
            if (sb.size() == 0) begin
               check("unexpected_output", 64'd1, 64'd0);
            end else begin
               mon_e = sb.pop_front();
               check("round", {60'h0, ks_round}, {60'h0, mon_e.round});
               if (mon_e.chk_sk)
                  check($sformatf("subkey_r%0d", mon_e.round), {16'h0, pc2_model(ks_cd)}, {16'h0, mon_e.sk});
               if (mon_e.chk_cd)
                  check($sformatf("cd_r%0d", mon_e.round), {8'h0, ks_cd}, {8'h0, mon_e.cd});
            end
            hs_count++;
         end
         prev_stall = ks_valid && !ks_ready;
         prev_cd    = ks_cd;
         prev_round = ks_round;
      end
   end

   task automatic load_key(input logic [63:0] k, input logic dec, input bit hold, output int acc);
      key_in    = rev64(k);
      decrypt   = dec;
      key_valid = 1'b1;
      acc       = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (key_ready) begin
            @(posedge clk);
            #1;
            acc = cyc;
            break;
         end
      end
      if (!hold) key_valid = 1'b0;
      check("key_accepted", {63'h0, acc >= 0}, 64'd1);
   endtask

   task automatic push_directed(input bit dec);
      logic [55:0] cd1;
      exp_t e;
      cd1 = {rev28(D1_DES), rev28(C1_DES)};
      for (int r = 0; r < 16; r++) begin
         e.round  = 4'(r);
         e.chk_sk = 1'b1;
         e.sk     = dec ? K_TAB[15 - r] : K_TAB[r];
         e.chk_cd = (r == 0) || (r == 15);
         if (dec) e.cd = (r == 0) ? pc1_model(KEY_A) : cd1;
         else     e.cd = (r == 0) ? cd1 : pc1_model(KEY_A);
         sb.push_back(e);
      end
   endtask

   task automatic push_random(input logic [63:0] k, input bit dec);
      logic [55:0] p;
      exp_t e;
      p = pc1_model(k);
      for (int r = 0; r < 16; r++) begin
         e.round  = 4'(r);
         e.chk_sk = 1'b0;
         e.sk     = '0;
         e.chk_cd = (r == 0) || (r == 15) || (dec && r == 1);
         if (dec) e.cd = (r == 0) ? p : (r == 1) ? brot(p, 1, 1'b0) : brot(p, 1, 1'b1);
         else     e.cd = (r == 0) ? brot(p, 1, 1'b1) : p;
         sb.push_back(e);
      end
   endtask

   task automatic drain(input int base, input bit bp);
      bit done = 0;
      for (int i = 0; i < 800 && !done; i++) begin
         @(posedge clk);
         #1;
         if (hs_count - base >= 16 && !ks_valid) done = 1;
         else if (bp) ks_ready = ((i % 12) < 5) ? 1'b0 : 1'($urandom_range(0, 1));
         else ks_ready = 1'b1;
      end
      ks_ready = 1'b1;
      check("handshakes_16", 64'(hs_count - base), 64'd16);
      check("valid_low_after_16", {63'h0, ks_valid}, 64'd0);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int acc_a, acc_b, base;
      logic [63:0] kb;
      bit found;

      rst_n = 1'b0; key_valid = 1'b0; key_in = '0; decrypt = 1'b0; ks_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ks_valid", {63'h0, ks_valid}, 64'd0);
      check("rst_key_ready", {63'h0, key_ready}, 64'd1);
      check("rst_busy", {63'h0, busy}, 64'd0);
      check("rst_ks_round", {60'h0, ks_round}, 64'd0);
      check("rst_ks_cd", {8'h0, ks_cd}, 64'd0);
      rst_n = 1'b1;

      // Encrypt vector; flipping decrypt after acceptance must not matter.
      base = hs_count;
      load_key(KEY_A, 1'b0, 1'b0, acc_a);
      push_directed(1'b0);
      decrypt = 1'b1;
      @(negedge clk);
      check("run_key_ready", {63'h0, key_ready}, 64'd0);
      check("run_busy", {63'h0, busy}, 64'd1);
      drain(base, 1'b0);

      // Decrypt vector.
      base = hs_count;
      load_key(KEY_A, 1'b1, 1'b0, acc_a);
      push_directed(1'b1);
      drain(base, 1'b0);

      // Backpressure in both orders.
      base = hs_count;
      load_key(KEY_A, 1'b0, 1'b0, acc_a);
      push_directed(1'b0);
      drain(base, 1'b1);
      base = hs_count;
      load_key(KEY_A, 1'b1, 1'b0, acc_a);
      push_directed(1'b1);
      drain(base, 1'b1);

      // Back-to-back: key_valid held high, second key offered during RUN.
      kb = {$urandom, $urandom};
      base = hs_count;
      load_key(KEY_A, 1'b0, 1'b1, acc_a);
      push_directed(1'b0);
      key_in  = rev64(kb);
      decrypt = 1'b1;
      @(negedge clk);
      check("b2b_key_ready_run", {63'h0, key_ready}, 64'd0);
      load_key(kb, 1'b1, 1'b0, acc_b);
      push_random(kb, 1'b1);
      check("b2b_accept_gap", 64'(acc_b - acc_a), 64'd17);
      drain(base + 16, 1'b0);

      // Wrap consistency on random keys.
      for (int n = 0; n < 3; n++) begin
         kb = {$urandom, $urandom};
         base = hs_count;
         load_key(kb, 1'b0, 1'b0, acc_a);
         push_random(kb, 1'b0);
         drain(base, 1'b0);
         base = hs_count;
         load_key(kb, 1'b1, 1'b0, acc_a);
         push_random(kb, 1'b1);
         drain(base, 1'b0);
      end

      // Asynchronous reset mid-run at round 7.
      load_key(KEY_A, 1'b0, 1'b0, acc_a);
      push_directed(1'b0);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (ks_valid && ks_round == 4'd7) found = 1;
      end
      check("reached_round7", {63'h0, found}, 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_ks_valid", {63'h0, ks_valid}, 64'd0);
      check("arst_key_ready", {63'h0, key_ready}, 64'd1);
      check("arst_ks_round", {60'h0, ks_round}, 64'd0);
      check("arst_busy", {63'h0, busy}, 64'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      base = hs_count;
      repeat (8) @(posedge clk);
      #1;
      check("post_rst_no_valid", {63'h0, ks_valid}, 64'd0);
      check("post_rst_no_hs", 64'(hs_count - base), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
